pkt_drain_ctrl: RTL and testbench
=================================

// Module: pkt_drain_ctrl
// PURPOSE
//  Consumer end of the upper packet FIFO's drain interface.
//  - Pops one action descriptor per packet: FWD, DROP or REWRITE.
//  - Requests exactly one packet via allow_drain and accepts its byte stream.
//  - Forwards, discards or patches one byte of the packet toward the egress mux.
// PARAMETERS
//  ACT_DEPTH  4   action-descriptor queue depth (power of 2, >=2)
//  OFF_W      11  width of byte-offset counter and rewrite offset
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, asynchronous, active-high
//  act_valid    in   1      action descriptor valid
//  act_op       in   2      00 FWD, 01 DROP, 10 REWRITE, 11 treated as DROP
//  act_off      in   OFF_W  REWRITE byte offset (0 = first byte)
//  act_byte     in   8      REWRITE replacement value
//  act_ready    out  1      action queue not full
//  allow_drain  out  1      drain request to packet FIFO
//  pkt_sop      in   1      1-cycle pulse from FIFO: drain of a packet started
//  in_valid     in   1      packet byte valid
//  in_data      in   8      packet byte
//  in_last      in   1      final byte of packet
//  in_ready     out  1      byte accept
//  out_valid    out  1      egress byte valid (registered)
//  out_data     out  8      egress byte (registered)
//  out_last     out  1      egress final byte (registered)
//  out_ready    in   1      egress accept
//  pkt_done     out  1      1-cycle pulse: last byte of a packet accepted on in_*
//  drop_cnt     out  16     dropped-packet count, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (async, any cycle, including mid-packet)
//  - State IDLE; action queue emptied; all outputs 0 except act_ready=1.
//  Action queue
//  - Synchronous FIFO of {op,off,byte}; push when act_valid&&act_ready.
//  - act_ready = !full, with no same-cycle pop bypass.
//  - Head is popped on the cycle the packet's in_last is accepted.
//  FSM
//  - IDLE:   queue non-empty -> REQ.
//  - REQ:    allow_drain=1 (Moore); stays high until pkt_sop is seen.
//            On pkt_sop=1 -> STREAM, clear byte offset.
//            Waits indefinitely if the FIFO is empty.
//  - STREAM: allow_drain=0; handles bytes per the head op.
//            Accepted in_last -> pop head, pkt_done=1 for 1 cycle, -> IDLE.
//  - in_ready=0 in IDLE and REQ.
//  Datapath, STREAM
//  - in_ready = DROP ? 1 : (!out_valid || out_ready).
//  - Accept = in_valid && in_ready; byte offset +1 per accept.
//  - Offset saturates at 2^OFF_W-1; no wrap, so no spurious rewrite.
//  - FWD:     accepted byte loads out_* next cycle (1-cycle latency).
//  - REWRITE: as FWD, but out_data=act_byte when offset==act_off.
//             act_off beyond packet length: packet forwarded unmodified.
//  - DROP:    bytes consumed at 1/cycle; out_valid stays 0.
//             drop_cnt +1 on the accepted in_last.
//  Output register
//  - out_valid cleared when out_ready && no new load.
//  - out_* stable while out_valid && !out_ready.
//  Overlap rule
//  - Next packet may start (IDLE->REQ) while the previous out_last is still held.
//  - Its first byte stalls on in_ready until the output register frees.
// TESTING
//  1. Push FWD; FIFO holds 3-byte pkt A0 A1 A2, out_ready=1
//     -> allow_drain high until pkt_sop; out A0,A1,A2 with out_last on A2; pkt_done once.
//  2. Push DROP; 5-byte pkt -> in_ready=1 for 5 accepts, out_valid never 1, drop_cnt=1.
//  3. Push REWRITE off=2 byte=8'hEE; pkt 10 11 12 13 -> out 10 11 EE 13.
//  4. FWD; toggle out_ready 1,0,0,1 -> in_ready tracks it; no byte lost or duplicated.
//  5. Push 5 actions with no drain -> act_ready=0 after 4th; 5th held until first pop.
//  6. Assert rst mid-STREAM -> outputs 0 immediately, queue empty, allow_drain=0.

Source files
------------

// File: rtl/pkt_drain_ctrl.sv
// pkt_drain_ctrl: pops per-packet actions, requests one packet at a time and forwards/drops/patches its bytes
module pkt_drain_ctrl #(
    parameter int ACT_DEPTH = 4,
    parameter int OFF_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act_valid,
    input  logic [1:0]       act_op,
    input  logic [OFF_W-1:0] act_off,
    input  logic [7:0]       act_byte,
    output logic             act_ready,
    output logic             allow_drain,
    input  logic             pkt_sop,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             pkt_done,
    output logic [15:0]      drop_cnt
);
    localparam int AW = $clog2(ACT_DEPTH);
    localparam int EW = 2 + OFF_W + 8;
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, STREAM = 2'd2;

    logic [EW-1:0]    mem_q [ACT_DEPTH];
    logic [EW-1:0]    mem_d [ACT_DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [1:0]       state_q, state_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d, pkt_done_q, pkt_done_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [EW-1:0]    head;
    logic             full, empty, push, is_drop, is_rw, acc, last_acc, ld;

    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty     = wr_q == rd_q;
    assign push      = act_valid && !full;
    assign head      = mem_q[rd_q[AW-1:0]];
    // op 11 is reserved and handled as DROP
    assign is_drop   = head[EW-1 -: 2] == 2'b01 || head[EW-1 -: 2] == 2'b11;
    assign is_rw     = head[EW-1 -: 2] == 2'b10;
    assign in_ready  = state_q == STREAM && (is_drop || !out_valid_q || out_ready);
    assign acc       = in_valid && in_ready;
    assign last_acc  = acc && in_last;
    assign ld        = acc && !is_drop;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q[AW-1:0]] = {act_op, act_off, act_byte};
        wr_d        = wr_q + (AW+1)'(push);
        rd_d        = rd_q + (AW+1)'(last_acc);
        state_d     = state_q == IDLE   ? (empty ? IDLE : REQ) :
                      state_q == REQ    ? (pkt_sop ? STREAM : REQ) :
                      state_q == STREAM ? (last_acc ? IDLE : STREAM) : IDLE;
        off_d       = (state_q == REQ && pkt_sop) ? '0 :
                      (acc && off_q != '1) ? off_q + OFF_W'(1) : off_q;
        out_valid_d = ld ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_data_d  = !ld ? out_data_q :
                      (is_rw && off_q == head[8 +: OFF_W]) ? head[7:0] : in_data;
        out_last_d  = ld ? in_last : out_last_q;
        pkt_done_d  = last_acc;
        drop_cnt_d  = (last_acc && is_drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ACT_DEPTH; i++) mem_q[i] <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            state_q     <= IDLE;
            off_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            state_q     <= state_d;
            off_q       <= off_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            pkt_done_q  <= pkt_done_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign act_ready   = !full;
    assign allow_drain = state_q == REQ;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign pkt_done    = pkt_done_q;
    assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_pkt_drain_ctrl.sv
// tb_pkt_drain_ctrl: scoreboard bench; a FIFO model feeds packets, a monitor checks egress bytes
module tb_pkt_drain_ctrl;
    logic        clk = 0, rst = 1;
    logic        act_valid = 0, act_ready, allow_drain, pkt_sop = 0;
    logic [1:0]  act_op = 0;
    logic [10:0] act_off = 0;
    logic [7:0]  act_byte = 0, in_data = 0, out_data;
    logic        in_valid = 0, in_last = 0, in_ready, out_valid, out_last, out_ready = 1, pkt_done;
    logic [15:0] drop_cnt;
    logic [8:0]  sb[$];
    int          n_chk = 0, n_pass = 0, done_cnt = 0;

    pkt_drain_ctrl dut (
        .clk(clk), .rst(rst), .act_valid(act_valid), .act_op(act_op), .act_off(act_off),
        .act_byte(act_byte), .act_ready(act_ready), .allow_drain(allow_drain), .pkt_sop(pkt_sop),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .pkt_done(pkt_done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (pkt_done) done_cnt++;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", {out_last, out_data}, -1);
            else chk("out_byte", {out_last, out_data}, sb.pop_front());
        end
    end

    task automatic push_act(input logic [1:0] op, input int off, input logic [7:0] b, output int waited);
        act_valid = 1; act_op = op; act_off = 11'(off); act_byte = b; waited = 0;
        forever begin
            @(negedge clk);
            if (act_ready || waited > 200) break;
            waited++;
        end
        if (waited > 200) chk("push_timeout", 1, 0);
        @(posedge clk); #1;
        act_valid = 0;
    endtask

    task automatic wait_allow();
        int t = 0;
        do begin @(negedge clk); t++; end while (!allow_drain && t < 100);
        chk("allow_drain_seen", allow_drain, 1);
        repeat (2) begin @(negedge clk); chk("allow_drain_held", allow_drain, 1); end
        @(posedge clk); #1;
    endtask

    // kind: 0 FWD, 1 DROP, 2 REWRITE; returns cycles spent streaming
    task automatic send_pkt(input int n, input logic [63:0] d, input int kind, input int off,
                            input logic [7:0] rb, input logic [3:0] pat, output int cyc);
        int i = 0; logic a; logic [7:0] b;
        wait_allow();
        pkt_sop = 1; @(posedge clk); #1; pkt_sop = 0;
        cyc = 0;
        while (i < n && cyc < 200) begin
            b = d[8*i +: 8];
            out_ready = pat[cyc % 4]; in_valid = 1; in_data = b; in_last = (i == n-1);
            @(negedge clk); a = in_ready;
            @(posedge clk); #1;
            if (a) begin
                if (kind != 1) sb.push_back({i == n-1, (kind == 2 && i == off) ? rb : b});
                i++;
            end
            cyc++;
        end
        if (i < n) chk("stream_timeout", i, n);
        in_valid = 0; in_last = 0; out_ready = 1;
    endtask

    int w, c, d0;
    initial begin
        #12 rst = 0;
        @(posedge clk); #1;
        chk("rst_act_ready", act_ready, 1);
        chk("rst_allow", allow_drain, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        // FWD A0 A1 A2
        d0 = done_cnt;
        push_act(2'b00, 0, 0, w);
        send_pkt(3, 64'hA2A1A0, 0, 0, 0, 4'hF, c);
        repeat (3) @(posedge clk); #1;
        chk("fwd_done_once", done_cnt - d0, 1);
        // DROP 5 bytes at one per cycle
        push_act(2'b01, 0, 0, w);
        send_pkt(5, 64'h0504030201, 1, 0, 0, 4'hF, c);
        chk("drop_cycles", c, 5);
        @(posedge clk); #1;
        chk("drop_cnt_1", drop_cnt, 1);
        // REWRITE off 2 -> 10 11 EE 13
        push_act(2'b10, 2, 8'hEE, w);
        send_pkt(4, 64'h13121110, 2, 2, 8'hEE, 4'hF, c);
        // REWRITE past packet end leaves it unmodified; op 11 drops
        push_act(2'b10, 9, 8'h99, w);
        send_pkt(3, 64'h333231, 2, 9, 8'h99, 4'hF, c);
        push_act(2'b11, 0, 0, w);
        send_pkt(2, 64'h4241, 1, 0, 0, 4'hF, c);
        @(posedge clk); #1;
        chk("drop_cnt_2", drop_cnt, 2);
        // FWD with out_ready 1,0,0,1
        push_act(2'b00, 0, 0, w);
        send_pkt(5, 64'h5554535251, 0, 0, 0, 4'b1001, c);
        // queue fills after 4 actions; 5th waits for first pop
        for (int k = 0; k < 4; k++) push_act(2'b00, 0, 0, w);
        @(negedge clk);
        chk("act_ready_full", act_ready, 0);
        @(posedge clk); #1;
        fork
            push_act(2'b10, 0, 8'h55, w);
            send_pkt(1, 64'h60, 0, 0, 0, 4'hF, c);
        join
        chk("fifth_held", w > 0, 1);
        for (int k = 1; k < 4; k++) send_pkt(1, 64'(8'h60 + k), 0, 0, 0, 4'hF, c);
        send_pkt(1, 64'h00, 2, 0, 8'h55, 4'hF, c);
        repeat (3) @(posedge clk); #1;
        // reset mid-stream with the output register loaded
        push_act(2'b00, 0, 0, w);
        push_act(2'b00, 0, 0, w);
        wait_allow();
        pkt_sop = 1; @(posedge clk); #1; pkt_sop = 0;
        out_ready = 0; in_valid = 1; in_data = 8'h77;
        repeat (3) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_allow", allow_drain, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_act_ready", act_ready, 1);
        chk("arst_drop_cnt", drop_cnt, 0);
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1; rst = 0;
        repeat (4) begin @(negedge clk); chk("arst_queue_empty", allow_drain, 0); end
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
